// File: rtl/fft_pkg.sv
// Shared FFT-path definitions: Q1.15 limits, descale FSM states and the
// 32-bit to Q1.15 saturation helper.
package fft_pkg;

  localparam int                DATA_W  = 16;
  localparam logic [DATA_W-1:0] Q15_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] Q15_MIN = 16'h8000;

  typedef enum logic {IDLE, RUN} descale_state_e;

  // Returns {overflow, saturated value}.
  function automatic logic [DATA_W:0] sat_q15(input logic signed [31:0] v);
    if (v > 32'sd32767)       return {1'b1, Q15_MAX};
    else if (v < -32'sd32768) return {1'b1, Q15_MIN};
    else                      return {1'b0, v[DATA_W-1:0]};
  endfunction

endpackage

// File: rtl/descale_shift_sat.sv
// One sample component: S1 sign-extends and shifts left, S2 saturates or
// wraps into Q1.15 and registers the result.
module descale_shift_sat
  import fft_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_s1_ld,
  input  logic              i_s2_ld,
  input  logic              i_sat_en,
  input  logic [3:0]        i_shift,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_ovf_s1,
  output logic              o_ovf
);

  logic signed [31:0] r_s1_val;
  logic [DATA_W-1:0]  r_data;
  logic               r_ovf;
  logic signed [31:0] w_ext;
  logic [DATA_W:0]    w_sat;

  assign w_ext    = {{(32-DATA_W){i_data[DATA_W-1]}}, i_data};
  assign w_sat    = sat_q15(r_s1_val);
  assign o_ovf_s1 = w_sat[DATA_W];
  assign o_data   = r_data;
  assign o_ovf    = r_ovf;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_val <= '0;
      r_data   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (i_s1_ld) r_s1_val <= w_ext <<< i_shift;
      if (i_s2_ld) begin
        // Wrap mode keeps the low bits of the shifted value.
        r_data <= (i_sat_en || !w_sat[DATA_W]) ? w_sat[DATA_W-1:0] : r_s1_val[DATA_W-1:0];
        r_ovf  <= w_sat[DATA_W];
      end
    end
  end

endmodule

// File: rtl/descale_unit.sv
// Undoes the FFT block-exponent rescale: per-frame shift latch, 2-stage
// shift/saturate pipeline with global stall, frame tracking and statistics.
module descale_unit #(
  parameter int DATA_W     = 16,
  parameter int FFT_LENGTH = 1024,
  parameter int MAX_SHIFT  = 15,
  parameter int CNT_W      = 13
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              descale_en_i,
  input  logic              saturation_en_i,
  input  logic [7:0]        scale_factor_i,
  input  logic [DATA_W-1:0] data_real_i,
  input  logic [DATA_W-1:0] data_imag_i,
  input  logic              data_valid_i,
  input  logic              data_last_i,
  output logic              data_ready_o,
  output logic [DATA_W-1:0] data_real_o,
  output logic [DATA_W-1:0] data_imag_o,
  output logic              data_valid_o,
  output logic              data_last_o,
  input  logic              data_ready_i,
  output logic              frame_active_o,
  output logic [3:0]        applied_shift_o,
  output logic [CNT_W-1:0]  sat_count_o,
  output logic              overflow_o,
  output logic              frame_error_o
);

  fft_pkg::descale_state_e r_state;
  logic [CNT_W-1:0] r_cnt, r_run_sat, r_sat_cnt, w_cnt, w_run_next;
  logic [3:0]       r_shift, w_shift;
  logic             r_s1_valid, r_s1_last, r_s2_valid, r_s2_last, r_ovf, r_ferr;
  logic             w_adv, w_in_xfer, w_out_xfer, w_start, w_is_last;
  logic             w_ovf_s1_re, w_ovf_s1_im, w_ovf_re, w_ovf_im;

  assign data_ready_o = !reset_i && (!r_s2_valid || data_ready_i);
  assign w_adv        = data_ready_o;
  assign w_in_xfer    = data_valid_i && data_ready_o;
  assign w_out_xfer   = r_s2_valid && data_ready_i;
  assign w_start      = w_in_xfer && (r_state == fft_pkg::IDLE);
  assign w_cnt        = (r_state == fft_pkg::IDLE) ? '0 : r_cnt;
  assign w_is_last    = (w_cnt == CNT_W'(FFT_LENGTH - 1));
  assign w_run_next   = ((w_ovf_re || w_ovf_im) && r_run_sat != '1) ? r_run_sat + CNT_W'(1) : r_run_sat;

  // The shift is resolved at input time and baked into the S1 value, so a
  // new frame's latch never touches samples of the previous frame.
  always_comb begin
    w_shift = r_shift;
    if (r_state == fft_pkg::IDLE) begin
      if (!descale_en_i)                          w_shift = '0;
      else if (scale_factor_i > 8'(MAX_SHIFT))    w_shift = 4'(MAX_SHIFT);
      else                                        w_shift = scale_factor_i[3:0];
    end
  end

  descale_shift_sat u_re (
    .i_clk(clk_i), .i_rst(reset_i), .i_s1_ld(w_in_xfer), .i_s2_ld(w_adv && r_s1_valid),
    .i_sat_en(saturation_en_i), .i_shift(w_shift), .i_data(data_real_i),
    .o_data(data_real_o), .o_ovf_s1(w_ovf_s1_re), .o_ovf(w_ovf_re)
  );

  descale_shift_sat u_im (
    .i_clk(clk_i), .i_rst(reset_i), .i_s1_ld(w_in_xfer), .i_s2_ld(w_adv && r_s1_valid),
    .i_sat_en(saturation_en_i), .i_shift(w_shift), .i_data(data_imag_i),
    .o_data(data_imag_o), .o_ovf_s1(w_ovf_s1_im), .o_ovf(w_ovf_im)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= fft_pkg::IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_ovf      <= 1'b0;
      r_ferr     <= 1'b0;
      r_run_sat  <= '0;
      r_sat_cnt  <= '0;
    end else begin
      r_ferr <= w_in_xfer && (data_last_i != w_is_last);
      if (w_in_xfer) begin
        if (w_start) r_shift <= w_shift;
        if (w_is_last) begin
          r_state <= fft_pkg::IDLE;
          r_cnt   <= '0;
        end else begin
          r_state <= fft_pkg::RUN;
          r_cnt   <= w_cnt + CNT_W'(1);
        end
      end
      if (w_adv) begin
        r_s1_valid <= data_valid_i;
        r_s1_last  <= data_valid_i && w_is_last;
        r_s2_valid <= r_s1_valid;
        r_s2_last  <= r_s1_last;
      end
      // Anything entering S2 on a frame-start edge is the previous frame's tail.
      if (w_start)
        r_ovf <= 1'b0;
      else if (w_adv && r_s1_valid && (w_ovf_s1_re || w_ovf_s1_im))
        r_ovf <= 1'b1;
      // Counted on leaving S2, so the running total always belongs to the
      // frame whose samples are draining.
      if (w_out_xfer) begin
        if (r_s2_last) begin
          r_sat_cnt <= w_run_next;
          r_run_sat <= '0;
        end else begin
          r_run_sat <= w_run_next;
        end
      end
    end
  end

  assign data_valid_o    = r_s2_valid;
  assign data_last_o     = r_s2_last;
  assign frame_active_o  = (r_state == fft_pkg::RUN);
  assign applied_shift_o = r_shift;
  assign sat_count_o     = r_sat_cnt;
  assign overflow_o      = r_ovf;
  assign frame_error_o   = r_ferr;

endmodule

// File: tb/tb_descale_unit.sv
// Directed bench for descale_unit with FFT_LENGTH=8: scoreboard of expected
// output samples plus per-frame statistics model.
module tb_descale_unit;
  localparam int N = 8;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        descale_en_i = 1'b0, saturation_en_i = 1'b0;
  logic [7:0]  scale_factor_i = '0;
  logic [15:0] data_real_i = '0, data_imag_i = '0;
  logic        data_valid_i = 1'b0, data_last_i = 1'b0, data_ready_i = 1'b0;
  logic        data_ready_o, data_valid_o, data_last_o;
  logic [15:0] data_real_o, data_imag_o;
  logic        frame_active_o, overflow_o, frame_error_o;
  logic [3:0]  applied_shift_o;
  logic [12:0] sat_count_o;

  always #5 clk_i = ~clk_i;

  descale_unit #(.DATA_W(16), .FFT_LENGTH(N), .MAX_SHIFT(15), .CNT_W(13)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .descale_en_i(descale_en_i),
    .saturation_en_i(saturation_en_i), .scale_factor_i(scale_factor_i),
    .data_real_i(data_real_i), .data_imag_i(data_imag_i), .data_valid_i(data_valid_i),
    .data_last_i(data_last_i), .data_ready_o(data_ready_o), .data_real_o(data_real_o),
    .data_imag_o(data_imag_o), .data_valid_o(data_valid_o), .data_last_o(data_last_o),
    .data_ready_i(data_ready_i), .frame_active_o(frame_active_o),
    .applied_shift_o(applied_shift_o), .sat_count_o(sat_count_o),
    .overflow_o(overflow_o), .frame_error_o(frame_error_o)
  );

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic        last;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0, cyc = 0;
  int   mcnt = 0, mshift = 0, msat_run = 0, msat_last = 0;
  logic movf = 1'b0, lat_chk = 1'b0;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent model: exact integer product, then range test.
  function automatic logic [16:0] model(input logic [15:0] x, input int sh, input logic sat);
    longint v;
    logic [63:0] u;
    v = longint'($signed(x)) * (64'sd1 << sh);
    u = v;
    if (v > 32767)       return {1'b1, sat ? 16'h7FFF : u[15:0]};
    else if (v < -32768) return {1'b1, sat ? 16'h8000 : u[15:0]};
    else                 return {1'b0, u[15:0]};
  endfunction

  task automatic step(input logic v, input logic [15:0] re, input logic [15:0] im,
                      input logic last, input logic rdy, output logic acc);
    exp_t e;
    logic [16:0] r, i;
    logic tl, ferr_exp;
    data_valid_i = v; data_real_i = re; data_imag_i = im;
    data_last_i = last; data_ready_i = rdy;
    #1;
    if (data_valid_o && data_ready_i) begin
      if (sb.size() == 0) chk("out_when_empty", {31'b0, data_valid_o}, 0);
      else begin
        e = sb.pop_front();
        chk("real", {16'b0, data_real_o}, {16'b0, e.re});
        chk("imag", {16'b0, data_imag_o}, {16'b0, e.im});
        chk("last", {31'b0, data_last_o}, {31'b0, e.last});
        if (lat_chk) chk("latency", cyc - e.cyc, 2);
      end
    end
    acc = v && data_ready_o;
    ferr_exp = 1'b0;
    if (acc) begin
      if (mcnt == 0) begin
        mshift = !descale_en_i ? 0 : (scale_factor_i > 15 ? 15 : int'(scale_factor_i));
        movf = 1'b0;
      end
      tl = (mcnt == N-1);
      r = model(re, mshift, saturation_en_i);
      i = model(im, mshift, saturation_en_i);
      if (r[16] || i[16]) begin msat_run++; movf = 1'b1; end
      ferr_exp = (last != tl);
      e = '{re: r[15:0], im: i[15:0], last: tl, cyc: cyc};
      sb.push_back(e);
      if (tl) begin mcnt = 0; msat_last = msat_run; msat_run = 0; end
      else mcnt++;
    end
    @(negedge clk_i);
    chk("frame_error", {31'b0, frame_error_o}, {31'b0, ferr_exp});
    chk("frame_active", {31'b0, frame_active_o}, {31'b0, mcnt != 0});
  endtask

  task automatic send(input logic [15:0] re, input logic [15:0] im, input logic last, input bit rnd);
    logic a;
    a = 1'b0;
    for (int k = 0; k < 50 && !a; k++)
      step(1'b1, re, im, last, rnd ? 1'($urandom_range(0, 1)) : 1'b1, a);
    if (!a) chk("accept_timeout", {31'b0, a}, 1);
  endtask

  task automatic drain();
    logic a;
    for (int k = 0; k < 20 && sb.size() > 0; k++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, a);
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_sat_count"}, {19'b0, sat_count_o}, msat_last);
    chk({tag, "_overflow"}, {31'b0, overflow_o}, {31'b0, movf});
    chk({tag, "_shift"}, {28'b0, applied_shift_o}, mshift);
  endtask

  task automatic do_reset();
    reset_i = 1'b1; data_valid_i = 1'b0; data_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rst_ready", {31'b0, data_ready_o}, 0);
    chk("rst_valid", {31'b0, data_valid_o}, 0);
    chk("rst_last", {31'b0, data_last_o}, 0);
    chk("rst_data", {data_real_o, data_imag_o}, 0);
    chk("rst_misc", {frame_active_o, overflow_o, frame_error_o, applied_shift_o}, 0);
    chk("rst_sat", {19'b0, sat_count_o}, 0);
    sb.delete();
    mcnt = 0; mshift = 0; msat_run = 0; msat_last = 0; movf = 1'b0;
    reset_i = 1'b0;
  endtask

  initial begin
    do_reset();

    // Pass-through with a nonzero scale factor present.
    lat_chk = 1'b1;
    descale_en_i = 1'b0; scale_factor_i = 8'd5;
    for (int s = 0; s < N; s++) send(16'h2000, 16'hE000, s == N-1, 1'b0);
    drain(); check_stats("pass");

    // In-range shift by 2.
    descale_en_i = 1'b1; scale_factor_i = 8'd2;
    for (int s = 0; s < N; s++) send(16'h1000, 16'hF800, s == N-1, 1'b0);
    drain(); check_stats("shift2");

    // Saturation, then the same frame wrapping.
    scale_factor_i = 8'd3; saturation_en_i = 1'b1;
    for (int s = 0; s < N; s++) send(16'h2000, 16'hC000, s == N-1, 1'b0);
    drain(); check_stats("sat");
    saturation_en_i = 1'b0;
    for (int s = 0; s < N; s++) send(16'h2000, 16'hC000, s == N-1, 1'b0);
    drain(); check_stats("wrap");

    // Back-to-back frames, random backpressure, mid-frame scale changes.
    lat_chk = 1'b0; saturation_en_i = 1'b1; scale_factor_i = 8'd1;
    for (int s = 0; s < N; s++) begin
      if (s == 3) begin scale_factor_i = 8'd9; descale_en_i = 1'b0; end
      send(16'($urandom), 16'($urandom), s == N-1, 1'b1);
    end
    scale_factor_i = 8'd4; descale_en_i = 1'b1;
    for (int s = 0; s < N; s++) begin
      if (s == 1) scale_factor_i = 8'd0;
      send(16'($urandom), 16'($urandom), s == N-1, 1'b1);
    end
    drain(); check_stats("b2b");

    // Framing error on sample 5, clamp of an oversized exponent to 15.
    scale_factor_i = 8'd20;
    for (int s = 0; s < N; s++) send(s[0] ? 16'h0001 : 16'h0000, 16'hFFFF, s == 4 || s == N-1, 1'b0);
    drain(); check_stats("ferr_clamp");

    // Reset after 3 of 8 samples, then a clean frame with a new shift.
    scale_factor_i = 8'd2;
    for (int s = 0; s < 3; s++) send(16'h0100, 16'h0200, 1'b0, 1'b0);
    do_reset();
    scale_factor_i = 8'd6; lat_chk = 1'b1;
    for (int s = 0; s < N; s++) send(16'(s * 16'h0123), 16'(16'h8000 + s), s == N-1, 1'b0);
    drain(); check_stats("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/descale_unit.md
Name: descale_unit

Overview:
- Inverse of the FFT overflow-rescale path. It consumes FFT output samples that carry an accumulated block exponent (scale_factor) and shifts each sample left by that exponent to restore true magnitude. Overflow is handled by saturation or wrap.
- Sits between the FFT core output and the output buffer or host interface.
- Provides frame tracking, valid/ready backpressure, and per-frame saturation statistics.

Parameters:
DATA_W, 16, sample width per component (Q1.15 signed)
FFT_LENGTH, 1024, samples per frame (power of 2, 8..4096)
MAX_SHIFT, 15, upper clamp on applied shift
CNT_W, 13, width of sample/saturation counters (must be >= log2(FFT_LENGTH)+1)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
descale_en_i  in  1  1=apply shift, 0=pass-through (shift 0)
saturation_en_i  in  1  1=saturate on overflow, 0=wrap
scale_factor_i  in  8  block exponent from rescale path, sampled at frame start
data_real_i  in  16  input real sample
data_imag_i  in  16  input imag sample
data_valid_i  in  1  input valid
data_last_i  in  1  input end-of-frame marker
data_ready_o  out  1  input ready
data_real_o  out  16  descaled real
data_imag_o  out  16  descaled imag
data_valid_o  out  1  output valid
data_last_o  out  1  output end-of-frame, aligned with sample FFT_LENGTH-1
data_ready_i  in  1  downstream ready
frame_active_o  out  1  high while state=RUN
applied_shift_o  out  4  shift latched for current/last frame
sat_count_o  out  CNT_W  saturated/wrapped samples in last completed frame
overflow_o  out  1  sticky: any component overflowed this frame; cleared at next frame start
frame_error_o  out  1  one-cycle pulse: data_last_i disagrees with internal count

Behaviour:
- Reset (sync, reset_i=1 at clk edge): all outputs 0 and data_ready_o=0 during reset; state=IDLE; pipeline emptied; counters 0. Reset mid-frame discards in-flight samples; no data_last_o is emitted for them.
- Handshake:
  - Input transfer = data_valid_i & data_ready_o.
  - Output transfer = data_valid_o & data_ready_i.
  - data_ready_o = !reset_i & (!s2_valid | data_ready_i): global stall, no combinational path from data_valid_i.
  - Output signals are held stable while data_valid_o=1 and data_ready_i=0.
- Pipeline:
  - 2 stages. Latency is 2 cycles from input transfer to data_valid_o when not stalled. Throughput is 1 sample/cycle.
  - S1: sign-extend each component to 32 bits, then arithmetic left shift by shift_q.
  - S2: range check and saturate or wrap; register the outputs.
- Shift rule:
  - shift_q = descale_en_i ? min(scale_factor_i, MAX_SHIFT) : 0.
  - shift_q is latched on the first input transfer of a frame (the IDLE->RUN transfer) and is held for the whole frame. scale_factor_i and descale_en_i changes mid-frame are ignored.
- Overflow rule:
  - A component overflows if the shifted 32-bit value lies outside [-32768, 32767].
  - If saturation_en_i=1: positive overflow -> 16'h7FFF, negative -> 16'h8000.
  - If saturation_en_i=0: output is the low 16 bits.
  - A sample counts once in the saturation counter even if both components overflow.
- State machine:
  - IDLE: waits for the first input transfer. On that transfer, latch shift, clear the overflow flag and running counter, then go to RUN.
  - RUN: count input transfers. The transfer with count==FFT_LENGTH-1 gets the internal last tag; on it go to IDLE.
  - data_last_i is ignored for framing. If data_last_i=1 at count!=FFT_LENGTH-1, or data_last_i=0 at count==FFT_LENGTH-1, pulse frame_error_o one cycle after that transfer.
- Last-frame statistics:
  - When the last-tagged sample leaves S2 (output transfer), the running saturation count copies to sat_count_o.
  - applied_shift_o updates at frame start.
- Back-to-back frames: the IDLE->RUN transfer may occur in the cycle after the last transfer. The next frame's shift latch must not affect samples of the previous frame still in flight, so the shift travels down the pipeline with each sample.
- Simultaneous events: frame-start clear of overflow_o takes priority over an overflow from the previous frame's tail sample. That tail overflow is attributed to the previous frame's count only.
- Counters saturate at all-ones, never wrap.

Decomposition:
- Shared package fft_pkg: DATA_W, Q15_MAX=16'h7FFF, Q15_MIN=16'h8000, the state enum descale_state_e {IDLE, RUN}, and function sat_q15(int32) returning a 16-bit value plus an overflow bit.
- One sub-module, descale_shift_sat: per-component shift plus saturate, instantiated twice (real and imag).

Test Plan:
- Pass-through: descale_en_i=0, scale=5, real=16'h2000, imag=16'hE000 -> outputs 2000/E000 after 2 cycles; overflow_o=0.
- Shift in range: scale=2, real=16'h1000, imag=16'hF800 -> 4000/E000; applied_shift_o=2; sat_count_o=0 at frame end.
- Saturation: scale=3, saturation_en_i=1, real=16'h2000, imag=16'hC000 -> 7FFF/8000; overflow_o=1. With saturation_en_i=0, the same input gives 0000/0000.
- Framing and backpressure: FFT_LENGTH=8, random data_ready_i toggling, scale change mid-frame -> 8 outputs in order; data_last_o on the 8th only; shift unchanged within the frame.
- Frame error: data_last_i asserted on the 5th sample (FFT_LENGTH=8) -> frame_error_o pulses once; the frame still ends after 8 samples.
- Reset mid-frame: reset_i asserted after 3 of 8 samples -> all outputs 0; next frame starts cleanly with a new shift; no spurious data_last_o.
